// File: rtl/heap_engine_p_pkg.sv
// Shared definitions for the heap engine: command encodings, FSM state type
// and implicit-tree index helpers.
package heap_pkg;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SIFT_UP   = 2'd1;
  localparam state_t ST_SIFT_DOWN = 2'd2;
  localparam state_t ST_FIN       = 2'd3;

  // parent(0) is clamped to 0 so the root never produces a wrapped index
  function automatic int unsigned parent(input int unsigned i);
    return (i == 0) ? 0 : ((i - 1) >> 1);
  endfunction

  function automatic int unsigned left(input int unsigned i);
    return 2 * i + 1;
  endfunction

  function automatic int unsigned right(input int unsigned i);
    return 2 * i + 2;
  endfunction

endpackage

// File: rtl/heap_engine_p_child_sel.sv
// Picks the better of two child slots and decides whether it should swap with
// the current slot. Ties between children favour the left one.
module heap_child_sel #(
  parameter int DATA_W   = 32,
  parameter int MAX_HEAP = 1,
  parameter int IDX_W    = 6
) (
  input  logic [IDX_W-1:0]  l_idx_i,
  input  logic [IDX_W-1:0]  r_idx_i,
  input  logic [DATA_W-1:0] l_key_i,
  input  logic [DATA_W-1:0] r_key_i,
  input  logic              l_vld_i,
  input  logic              r_vld_i,
  input  logic [DATA_W-1:0] cur_key_i,
  output logic [IDX_W-1:0]  c_idx_o,
  output logic              swap_o
);

  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MAX_HEAP != 0) ? (a > b) : (a < b);
  endfunction

  logic              pick_r;
  logic [DATA_W-1:0] c_key;

  always_comb begin
    pick_r  = r_vld_i && better(r_key_i, l_key_i);
    c_idx_o = pick_r ? r_idx_i : l_idx_i;
    c_key   = pick_r ? r_key_i : l_key_i;
    swap_o  = l_vld_i && better(c_key, cur_key_i);
  end

endmodule

// File: rtl/heap_engine_p.sv
// Binary-heap priority queue engine: push/pop/replace with one sift level per
// clock, root exposed combinationally as top.
module heap_engine_p
  import heap_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int MAX_HEAP = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] pop_data,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = CNT_W + 1;
  localparam int AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] pop_q, pop_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  l_idx, r_idx, p_idx, cnt_ext, c_idx, up_idx;
  logic              l_vld, r_vld, down_swap, up_swap;
  logic [DATA_W-1:0] l_key, r_key, cur_key, p_key, c_key;

  // Neighbour indices and keys of the slot currently being sifted
  assign cnt_ext = {1'b0, count_q};
  assign l_idx   = IDX_W'(left(32'(idx_q)));
  assign r_idx   = IDX_W'(right(32'(idx_q)));
  assign p_idx   = IDX_W'(parent(32'(idx_q)));
  assign l_vld   = l_idx < cnt_ext;
  assign r_vld   = r_idx < cnt_ext;
  assign l_key   = l_vld ? arr_q[AW'(l_idx)] : '0;
  assign r_key   = r_vld ? arr_q[AW'(r_idx)] : '0;
  assign cur_key = arr_q[AW'(idx_q)];
  assign p_key   = arr_q[AW'(p_idx)];
  assign c_key   = arr_q[AW'(c_idx)];

  heap_child_sel #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP), .IDX_W(IDX_W)) u_down (
    .l_idx_i  (l_idx),
    .r_idx_i  (r_idx),
    .l_key_i  (l_key),
    .r_key_i  (r_key),
    .l_vld_i  (l_vld),
    .r_vld_i  (r_vld),
    .cur_key_i(cur_key),
    .c_idx_o  (c_idx),
    .swap_o   (down_swap)
  );

  // Sift-up is the same compare with the node as sole "child" of its parent
  heap_child_sel #(.DATA_W(DATA_W), .MAX_HEAP(MAX_HEAP), .IDX_W(IDX_W)) u_up (
    .l_idx_i  (idx_q),
    .r_idx_i  (p_idx),
    .l_key_i  (cur_key),
    .r_key_i  (p_key),
    .l_vld_i  (idx_q != '0),
    .r_vld_i  (1'b0),
    .cur_key_i(p_key),
    .c_idx_o  (up_idx),
    .swap_o   (up_swap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    pop_d   = pop_q;
    err_d   = err_q;
    arr_d   = arr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = ST_FIN;
          case (op)
            OP_PUSH: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                arr_d[AW'(count_q)] = key;
                count_d = count_q + 1'b1;
                idx_d   = IDX_W'(count_q);
                state_d = ST_SIFT_UP;
              end
            end
            OP_POP: begin
              if (empty) begin
                err_d = 1'b1;
              end else begin
                pop_d    = arr_q[0];
                arr_d[0] = arr_q[AW'(count_q - 1'b1)];
                count_d  = count_q - 1'b1;
                idx_d    = '0;
                if (count_q != CNT_W'(1)) state_d = ST_SIFT_DOWN;
              end
            end
            OP_REPLACE: begin
              if (empty) begin
                err_d = 1'b1;
              end else begin
                pop_d    = arr_q[0];
                arr_d[0] = key;
                idx_d    = '0;
                state_d  = ST_SIFT_DOWN;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SIFT_UP: begin
        if (up_swap) begin
          arr_d[AW'(up_idx)] = p_key;
          arr_d[AW'(p_idx)]  = cur_key;
          idx_d = p_idx;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_SIFT_DOWN: begin
        if (down_swap) begin
          arr_d[AW'(c_idx)] = cur_key;
          arr_d[AW'(idx_q)] = c_key;
          idx_d = c_idx;
        end else begin
          state_d = ST_FIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      pop_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      pop_q   <= pop_d;
      err_q   <= err_d;
    end
  end

  // Key storage is deliberately left uncleared by reset; count gates validity
  always_ff @(posedge clk) begin
    arr_q <= arr_d;
  end

  assign busy     = (state_q == ST_SIFT_UP) || (state_q == ST_SIFT_DOWN);
  assign done     = (state_q == ST_FIN);
  assign err      = done && err_q;
  assign pop_data = pop_q;
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign top      = empty ? '0 : arr_q[0];

endmodule

// File: tb/tb_heap_engine_p.sv
// Directed and random checks of heap_engine_p in max- and min-heap modes
// against a flat-list priority-queue reference model.
module tb_heap_engine_p;

  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk = 1'b0;
  logic          reset, start, dsel;
  logic [1:0]    op;
  logic [DW-1:0] key;

  logic          busy_a, done_a, err_a, full_a, empty_a;
  logic [DW-1:0] pop_a, top_a;
  logic [CW-1:0] count_a;
  logic          busy_b, done_b, err_b, full_b, empty_b;
  logic [DW-1:0] pop_b, top_b;
  logic [CW-1:0] count_b;

  logic          busy, done, err, full, empty;
  logic [DW-1:0] pop_data, top;
  logic [CW-1:0] count;
  logic          start_a, start_b;

  always #5 clk = ~clk;

  assign start_a  = start & ~dsel;
  assign start_b  = start & dsel;
  assign busy     = dsel ? busy_b  : busy_a;
  assign done     = dsel ? done_b  : done_a;
  assign err      = dsel ? err_b   : err_a;
  assign full     = dsel ? full_b  : full_a;
  assign empty    = dsel ? empty_b : empty_a;
  assign pop_data = dsel ? pop_b   : pop_a;
  assign top      = dsel ? top_b   : top_a;
  assign count    = dsel ? count_b : count_a;

  heap_engine_p #(.DATA_W(DW), .DEPTH(DEP), .MAX_HEAP(1)) u_max (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .key(key),
    .busy(busy_a), .done(done_a), .err(err_a), .pop_data(pop_a), .top(top_a),
    .count(count_a), .full(full_a), .empty(empty_a)
  );

  heap_engine_p #(.DATA_W(DW), .DEPTH(DEP), .MAX_HEAP(0)) u_min (
    .clk(clk), .reset(reset), .start(start_b), .op(op), .key(key),
    .busy(busy_b), .done(done_b), .err(err_b), .pop_data(pop_b), .top(top_b),
    .count(count_b), .full(full_b), .empty(empty_b)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] pop;
    int            cnt;
    logic [DW-1:0] top;
  } exp_t;

  exp_t          sb[$];
  int unsigned   mq[$];
  bit            mmax;
  logic [DW-1:0] last_pop;
  int            ncmp = 0;
  int            nfail = 0;
  int            lat;
  logic          got_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int best_pos();
    int p = 0;
    for (int i = 1; i < mq.size(); i++)
      if (mmax ? (mq[i] > mq[p]) : (mq[i] < mq[p])) p = i;
    return p;
  endfunction

  task automatic model(input logic [1:0] o, input logic [DW-1:0] k);
    exp_t e;
    int   p;
    e.err = 1'b0;
    case (o)
      2'b01: if (mq.size() == DEP) e.err = 1'b1; else mq.push_back(k);
      2'b10: begin
        if (mq.size() == 0) e.err = 1'b1;
        else begin p = best_pos(); last_pop = mq[p]; mq.delete(p); end
      end
      2'b11: begin
        if (mq.size() == 0) e.err = 1'b1;
        else begin p = best_pos(); last_pop = mq[p]; mq.delete(p); mq.push_back(k); end
      end
      default: ;
    endcase
    e.pop = last_pop;
    e.cnt = mq.size();
    e.top = (mq.size() == 0) ? '0 : mq[best_pos()];
    sb.push_back(e);
  endtask

  task automatic finish_op(input int lat0, output int l);
    exp_t e;
    l = lat0;
    while (done !== 1'b1 && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
    chk("done_seen", done, 1'b1);
    got_err = err;
    e = sb.pop_front();
    chk("err", err, e.err);
    chk("pop_data", pop_data, e.pop);
    chk("count", count, e.cnt);
    chk("top", top, e.top);
    chk("full", full, e.cnt == DEP);
    chk("empty", empty, e.cnt == 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [DW-1:0] k, output int l);
    model(o, k);
    op = o; key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(1, l);
  endtask

  task automatic reset_all();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    last_pop = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; key = '0; dsel = 1'b0;
    mmax = 1'b1; last_pop = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_pop", pop_a, 0);
    chk("rst_top", top_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_empty_min", empty_b, 1);
    reset = 1'b0;

    // Max heap basics
    run(2'b01, 5, lat);  chk("lat_push_root", lat, 2);
    run(2'b01, 3, lat);  chk("lat_push_noswap", lat, 2);
    run(2'b01, 9, lat);  chk("lat_push_swap", lat, 3);
    chk("top9", top, 9);
    chk("count3", count, 3);
    run(2'b10, 0, lat);  chk("pop9", pop_data, 9);
    run(2'b10, 0, lat);  chk("pop5", pop_data, 5);
    run(2'b10, 0, lat);  chk("pop3", pop_data, 3);
    chk("empty_after_pops", empty, 1);
    chk("top_empty", top, 0);
    run(2'b10, 0, lat);  chk("lat_pop_empty", lat, 1);
    chk("err_pop_empty", got_err, 1);
    run(2'b00, 0, lat);  chk("lat_nop", lat, 1);

    for (int i = 1; i <= 8; i++) run(2'b01, i, lat);
    chk("full8", full, 1);
    chk("top8", top, 8);
    run(2'b01, 20, lat); chk("err_push_full", got_err, 1);
    chk("count_full", count, 8);
    run(2'b11, 0, lat);  chk("replace_pop", pop_data, 8);
    chk("replace_top", top, 7);
    chk("replace_count", count, 8);

    // Min heap with duplicate keys
    dsel = 1'b1; mmax = 1'b0; mq.delete(); last_pop = '0;
    run(2'b01, 40, lat);
    run(2'b01, 10, lat);
    run(2'b01, 30, lat);
    run(2'b01, 10, lat); chk("lat_equal_noswap", lat, 3);
    chk("min_top", top, 10);
    run(2'b10, 0, lat);  chk("min_pop0", pop_data, 10);
    run(2'b10, 0, lat);  chk("min_pop1", pop_data, 10);
    run(2'b10, 0, lat);  chk("min_pop2", pop_data, 30);
    run(2'b10, 0, lat);  chk("min_pop3", pop_data, 40);

    // Start while busy is ignored; reset mid-sift aborts
    dsel = 1'b0; mmax = 1'b1;
    reset_all();
    for (int i = 1; i <= 8; i++) run(2'b01, i, lat);
    model(2'b10, 0);
    op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_sift", busy, 1);
    op = 2'b01; key = 99; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(2, lat);
    chk("busy_push_ignored", count, 7);
    chk("busy_top", top, 7);

    op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_before_reset", busy, 1);
    reset_all();
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [1:0] o;
      r = $urandom_range(0, 9);
      o = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
      run(o, DW'($urandom_range(0, 20)), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/heap_engine_p.md
Name: heap_engine_p

Overview:
- Parametrised binary-heap priority queue engine; successor to heap_control.
- Holds up to DEPTH keys of DATA_W bits in an internal register array.
- Root holds the maximum key (MAX_HEAP=1) or the minimum key (MAX_HEAP=0).
- Supports push, pop, and a combined replace op. Reports full/empty, error and occupancy.
- Sits between a command source (start/op/key handshake) and consumers of the top element.

Parameters:
- DATA_W, 32, key width in bits; compare is unsigned.
- DEPTH, 16, maximum entry count; must be ≥2.
- MAX_HEAP, 1, 1 = max-heap, 0 = min-heap.
- CNT_W, $clog2(DEPTH+1), width of count/index (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- op  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
- key  in  DATA_W  key for PUSH/REPLACE; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = op rejected, heap unchanged.
- pop_data  out  DATA_W  removed root for POP/REPLACE; valid with done, held until the next POP/REPLACE.
- top  out  DATA_W  current root; 0 when empty.
- count  out  CNT_W  number of valid entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On reset: state=IDLE; count=0; busy=0; done=0; err=0; pop_data=0; top=0; empty=1; full=0.
  - The array is not cleared.
  - Reset mid-operation aborts the op; no done pulse is issued.
- "better(a,b)" means a>b when MAX_HEAP=1, a<b when MAX_HEAP=0. It is strict, so equal keys never swap.
- FSM states: IDLE, SIFT_UP, SIFT_DOWN, FIN.
- IDLE with start=1 (accept cycle T):
  - NOP: go to FIN; done at T+1, err=0.
  - PUSH with full=1: go to FIN with err=1.
  - PUSH otherwise: arr[count]<=key; count++; idx<=old count; go to SIFT_UP.
  - POP with empty=1: FIN with err=1.
  - POP otherwise: pop_data<=arr[0]; arr[0]<=arr[count-1]; count--; idx<=0. Go to SIFT_DOWN, or to FIN if the new count is 0.
  - REPLACE with empty=1: FIN with err=1.
  - REPLACE otherwise: pop_data<=arr[0]; arr[0]<=key; count unchanged; idx<=0; go to SIFT_DOWN. Replace on a full heap is legal.
- SIFT_UP, one level per cycle. p=(idx-1)>>1.
  - If idx==0 or !better(arr[idx],arr[p]): go to FIN.
  - Otherwise swap arr[idx] and arr[p], and idx<=p.
- SIFT_DOWN, one level per cycle. l=2idx+1, r=2idx+2; only indices < count are valid.
  - Pick c = the better valid child; on a tie, or if only l is valid, take l.
  - If there is no valid child or !better(arr[c],arr[idx]): go to FIN.
  - Otherwise swap and idx<=c.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
  - A new start is accepted in the cycle after FIN.
- Latency: done at cycle T+2+s, where s = number of swaps (NOP and error ops: T+1).
  - Worst case is T+2+floor(log2 DEPTH).
- start while busy is ignored; no queuing.
- Derived outputs:
  - top, full and empty are combinational from registered state.
  - They reflect the final heap in the done cycle.
- Index arithmetic uses CNT_W+1 bits so that 2idx+2 cannot overflow.

Decomposition:
- heap_pkg holds:
  - op encodings (OP_NOP, OP_PUSH, OP_POP, OP_REPLACE);
  - the FSM state typedef;
  - index helper functions parent/left/right.
- One combinational sub-module, heap_child_sel, parametrised on DATA_W and MAX_HEAP.
  - Inputs: arr[l], arr[r], validity flags, arr[idx].
  - Outputs: the selected child index and a swap flag.
  - It is reused by the SIFT_UP compare with r forced invalid.

Test Plan:
- Max mode, DEPTH=8: push 5, 3, 9 → top=9, count=3; the push of 9 gives done at T+3 (one swap), err=0.
- Continue: pop ×3 → pop_data 9, 5, 3; then empty=1, top=0; a 4th pop gives done at T+1 with err=1 and count=0.
- Push 1..8 ascending → full=1, top=8. Push 20 → err=1, count stays 8. Replace key 0 → pop_data=8, top=7, count=8.
- MAX_HEAP=0: push 40, 10, 30, 10 → top=10. Pops return 10, 10, 30, 40; the equal keys cause no swap.
- Assert start during busy with op=PUSH key=99 → ignored, count unchanged. Assert reset during SIFT_DOWN → next cycle count=0, busy=0, no done.
- Random push/pop sequence of 200 ops checked against a reference priority-queue model → pop_data and count always match.
